// File: rtl/alu_share_ctrl.sv
// Round-robin controller sharing one registered ALU between requesters A and B.
// One operation in flight: issue (IDLE) -> execute (EXEC) -> capture (WB) -> respond (RESP).
module alu_share_ctrl #(
  parameter int N = 32,
  parameter int P = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         a_req_valid,
  output logic         a_req_ready,
  input  logic [N-1:0] a_in1,
  input  logic [N-1:0] a_in2,
  input  logic [P-1:0] a_op,
  output logic         a_rsp_valid,
  input  logic         a_rsp_ready,
  input  logic         b_req_valid,
  output logic         b_req_ready,
  input  logic [N-1:0] b_in1,
  input  logic [N-1:0] b_in2,
  input  logic [P-1:0] b_op,
  output logic         b_rsp_valid,
  input  logic         b_rsp_ready,
  output logic [N-1:0] rsp_result,
  output logic         rsp_zero,
  output logic [N-1:0] alu_in1,
  output logic [N-1:0] alu_in2,
  output logic [P-1:0] alu_op,
  input  logic [N-1:0] alu_result,
  input  logic         alu_zero,
  output logic         busy
);

  typedef enum logic [1:0] {IDLE, EXEC, WB, RESP} state_t;

  state_t state, state_nxt;
  logic   last_grant;  // 1 = B was granted last
  logic   owner;       // 1 = B owns the op in flight
  logic   grant_a, grant_b;
  logic   rsp_fire;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    state_nxt = state;
    grant_a   = 1'b0;
    grant_b   = 1'b0;
    rsp_fire  = owner ? b_rsp_ready : a_rsp_ready;
    unique case (state)
      IDLE: begin
        // A reset cycle never grants, so a held request is not lost to the abort.
        if (!rst) begin
          grant_a = a_req_valid && (!b_req_valid || last_grant);
          grant_b = b_req_valid && (!a_req_valid || !last_grant);
        end
        if (grant_a || grant_b) state_nxt = EXEC;
      end
      EXEC:    state_nxt = WB;
      WB:      state_nxt = RESP;
      RESP:    if (rsp_fire) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign a_req_ready = grant_a;
  assign b_req_ready = grant_b;
  assign a_rsp_valid = (state == RESP) && !owner;
  assign b_rsp_valid = (state == RESP) && owner;
  assign busy        = (state != IDLE);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      owner      <= 1'b0;
      alu_in1    <= '0;
      alu_in2    <= '0;
      alu_op     <= '0;
      rsp_result <= '0;
      rsp_zero   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (grant_a || grant_b) begin
        owner      <= grant_b;
        last_grant <= grant_b;
        alu_in1    <= grant_b ? b_in1 : a_in1;
        alu_in2    <= grant_b ? b_in2 : a_in2;
        alu_op     <= grant_b ? b_op  : a_op;
      end
      // The equality flag is combinational from the operands, the result one clock later.
      if (state == EXEC) rsp_zero   <= alu_zero;
      if (state == WB)   rsp_result <= alu_result;
    end
  end

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Bench for alu_share_ctrl: models the shared ALU, keeps a transaction-level reference
// model compared every cycle, plus directed scenarios with hand-computed results.
module tb_alu_share_ctrl;
  localparam int N = 32;
  localparam int P = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         a_req_valid, a_req_ready, a_rsp_valid, a_rsp_ready;
  logic         b_req_valid, b_req_ready, b_rsp_valid, b_rsp_ready;
  logic [N-1:0] a_in1, a_in2, b_in1, b_in2;
  logic [P-1:0] a_op, b_op;
  logic [N-1:0] rsp_result, alu_in1, alu_in2, alu_result;
  logic         rsp_zero, alu_zero, busy;
  logic [P-1:0] alu_op;

  int total = 0;
  int bad   = 0;

  alu_share_ctrl #(.N(N), .P(P)) dut (
    .clk(clk), .rst(rst),
    .a_req_valid(a_req_valid), .a_req_ready(a_req_ready),
    .a_in1(a_in1), .a_in2(a_in2), .a_op(a_op),
    .a_rsp_valid(a_rsp_valid), .a_rsp_ready(a_rsp_ready),
    .b_req_valid(b_req_valid), .b_req_ready(b_req_ready),
    .b_in1(b_in1), .b_in2(b_in2), .b_op(b_op),
    .b_rsp_valid(b_rsp_valid), .b_rsp_ready(b_rsp_ready),
    .rsp_result(rsp_result), .rsp_zero(rsp_zero),
    .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_op(alu_op),
    .alu_result(alu_result), .alu_zero(alu_zero), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [N-1:0] alu_fn(input logic [P-1:0] op, input logic [N-1:0] x, input logic [N-1:0] y);
    case (op)
      4'b0000: return x & y;
      4'b0001: return x | y;
      4'b0010: return x + y;
      4'b0110: return x - y;
      4'b0111: return (x < y) ? x : y;
      4'b1100: return ~(x | y);
      default: return '0;
    endcase
  endfunction

  // The shared ALU: registered result, combinational equality flag.
  always_ff @(posedge clk) alu_result <= alu_fn(alu_op, alu_in1, alu_in2);
  assign alu_zero = (alu_in1 == alu_in2);

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: one transaction record, its age in cycles since acceptance,
  // and the values last delivered to a requester.
  bit           m_busy, m_owner, m_last;
  int           m_age;
  logic [N-1:0] m_cur_res, m_res, m_in1, m_in2;
  logic         m_cur_zero, m_zero;
  logic [P-1:0] m_op;

  always @(negedge clk) begin
    bit ga, gb, fire;
    if (rst) begin
      m_busy = 0; m_owner = 0; m_last = 1; m_age = 0;
      m_res = '0; m_zero = 0; m_in1 = '0; m_in2 = '0; m_op = '0;
    end else begin
      ga = !m_busy && a_req_valid && (!b_req_valid || m_last);
      gb = !m_busy && b_req_valid && (!a_req_valid || !m_last);
      check("busy", busy, m_busy);
      check("a_req_ready", a_req_ready, ga);
      check("b_req_ready", b_req_ready, gb);
      check("a_rsp_valid", a_rsp_valid, m_busy && m_age >= 3 && !m_owner);
      check("b_rsp_valid", b_rsp_valid, m_busy && m_age >= 3 && m_owner);
      check("alu_in1", alu_in1, m_in1);
      check("alu_in2", alu_in2, m_in2);
      check("alu_op", alu_op, m_op);
      if (!m_busy || m_age >= 3) begin
        check("rsp_result", rsp_result, m_busy ? m_cur_res : m_res);
        check("rsp_zero", rsp_zero, m_busy ? m_cur_zero : m_zero);
      end
      if (ga || gb) begin
        m_busy = 1; m_owner = gb; m_last = gb; m_age = 1;
        m_in1 = gb ? b_in1 : a_in1;
        m_in2 = gb ? b_in2 : a_in2;
        m_op  = gb ? b_op  : a_op;
        m_cur_res  = alu_fn(m_op, m_in1, m_in2);
        m_cur_zero = (m_in1 == m_in2);
      end else if (m_busy) begin
        fire = m_owner ? b_rsp_ready : a_rsp_ready;
        if (m_age < 3) m_age++;
        else if (fire) begin
          m_busy = 0; m_res = m_cur_res; m_zero = m_cur_zero;
        end
      end
    end
  end

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1; a_req_valid = 0; b_req_valid = 0; a_rsp_ready = 0; b_rsp_ready = 0;
    @(posedge clk); #1;
    rst = 0;
  endtask

  task automatic wait_grant(input bit is_b, input string name);
    bit found = 0;
    for (int i = 0; i < 12 && !found; i++) begin
      @(negedge clk);
      found = is_b ? b_req_ready : a_req_ready;
    end
    check({name, "_grant"}, found, 1);
  endtask

  task automatic wait_rsp(input bit is_b, input logic [N-1:0] er, input logic ez, input string name, output int lat);
    bit found = 0;
    lat = 0;
    for (int i = 0; i < 12 && !found; i++) begin
      @(negedge clk);
      lat++;
      found = is_b ? b_rsp_valid : a_rsp_valid;
    end
    check({name, "_rsp_seen"}, found, 1);
    check({name, "_result"}, rsp_result, er);
    check({name, "_zero"}, rsp_zero, ez);
  endtask

  task automatic ack(input bit is_b);
    @(posedge clk); #1;
    if (is_b) b_rsp_ready = 1; else a_rsp_ready = 1;
    @(posedge clk); #1;
    if (is_b) b_rsp_ready = 0; else a_rsp_ready = 0;
  endtask

  task automatic run_op(input bit is_b, input logic [P-1:0] op, input logic [N-1:0] x, input logic [N-1:0] y,
                        input logic [N-1:0] er, input logic ez, input string name);
    int lat;
    @(posedge clk); #1;
    if (is_b) begin b_req_valid = 1; b_op = op; b_in1 = x; b_in2 = y; end
    else      begin a_req_valid = 1; a_op = op; a_in1 = x; a_in2 = y; end
    wait_grant(is_b, name);
    @(posedge clk); #1;
    if (is_b) b_req_valid = 0; else a_req_valid = 0;
    wait_rsp(is_b, er, ez, name, lat);
    check({name, "_latency"}, lat, 3);
    ack(is_b);
  endtask

  task automatic rand_ops(output logic [P-1:0] op, output logic [N-1:0] x, output logic [N-1:0] y);
    logic [P-1:0] ops [7] = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100, 4'b0000};
    op = ops[$urandom_range(0, 6)];
    if ($urandom_range(0, 6) == 0) op = P'($urandom);
    x = $urandom;
    case ($urandom_range(0, 4))
      0:       y = x;
      1:       begin x = '1; y = N'($urandom_range(0, 2)); end
      default: y = $urandom;
    endcase
  endtask

  initial begin
    int lat;
    bit who, af, bf;
    logic [N-1:0] ex;
    logic         ez;
    rst = 1; a_req_valid = 0; b_req_valid = 0; a_rsp_ready = 0; b_rsp_ready = 0;
    a_in1 = '0; a_in2 = '0; a_op = '0; b_in1 = '0; b_in2 = '0; b_op = '0;
    repeat (2) @(posedge clk);
    #1 rst = 0;

    // Reset then a single add from A.
    @(negedge clk);
    check("t1_reset_busy", busy, 0);
    check("t1_reset_result", rsp_result, 0);
    run_op(0, 4'b0010, 32'd5, 32'd7, 32'd12, 1'b0, "t1_add");

    // Simultaneous requests straight out of reset: A wins the first tie.
    do_reset();
    a_req_valid = 1; a_op = 4'b0110; a_in1 = 32'd9; a_in2 = 32'd9;
    b_req_valid = 1; b_op = 4'b0001; b_in1 = 32'hF0; b_in2 = 32'h0F;
    @(negedge clk);
    check("t2_a_first", a_req_ready, 1);
    check("t2_b_waits", b_req_ready, 0);
    @(posedge clk); #1 a_req_valid = 0;
    wait_rsp(0, 32'd0, 1'b1, "t2_sub", lat);
    ack(0);
    wait_grant(1, "t2_or");
    @(posedge clk); #1 b_req_valid = 0;
    wait_rsp(1, 32'hFF, 1'b0, "t2_or", lat);
    ack(1);

    // Both requesters held valid for four operations: grants alternate A,B,A,B.
    @(posedge clk); #1;
    rand_ops(a_op, a_in1, a_in2); rand_ops(b_op, b_in1, b_in2);
    a_req_valid = 1; b_req_valid = 1;
    for (int k = 0; k < 4; k++) begin
      bit found = 0;
      for (int i = 0; i < 12 && !found; i++) begin
        @(negedge clk);
        found = a_req_ready || b_req_ready;
      end
      check("t3_grant_seen", found, 1);
      who = b_req_ready;
      check("t3_order", who, k[0]);
      ex = who ? alu_fn(b_op, b_in1, b_in2) : alu_fn(a_op, a_in1, a_in2);
      ez = who ? (b_in1 == b_in2) : (a_in1 == a_in2);
      @(posedge clk); #1;
      if (who) rand_ops(b_op, b_in1, b_in2); else rand_ops(a_op, a_in1, a_in2);
      if (k >= 2) begin
        if (who) b_req_valid = 0; else a_req_valid = 0;
      end
      wait_rsp(who, ex, ez, "t3_op", lat);
      ack(who);
    end
    a_req_valid = 0; b_req_valid = 0;

    // Backpressure from A while B waits; B's stray rsp_ready is ignored.
    @(posedge clk); #1;
    a_req_valid = 1; a_op = 4'b0010; a_in1 = 32'd1; a_in2 = 32'd2;
    wait_grant(0, "t4_a");
    @(posedge clk); #1;
    a_req_valid = 0;
    b_req_valid = 1; b_op = 4'b0000; b_in1 = 32'd5; b_in2 = 32'd3; b_rsp_ready = 1;
    wait_rsp(0, 32'd3, 1'b0, "t4_a", lat);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t4_hold_valid", a_rsp_valid, 1);
      check("t4_hold_result", rsp_result, 32'd3);
      check("t4_hold_busy", busy, 1);
      check("t4_b_blocked", b_req_ready, 0);
    end
    b_rsp_ready = 0;
    ack(0);
    wait_grant(1, "t4_b");
    @(posedge clk); #1 b_req_valid = 0;
    wait_rsp(1, 32'd1, 1'b0, "t4_b", lat);
    ack(1);

    // Edge opcodes and wrap-around.
    run_op(0, 4'b0101, 32'd4, 32'd6, 32'd0, 1'b0, "t5_undef");
    run_op(1, 4'b0010, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, "t5_wrap");
    run_op(0, 4'b0111, 32'd3, 32'd8, 32'd3, 1'b0, "t5_min");

    // Reset while the op is in WB: aborted, no response, then a clean op.
    @(posedge clk); #1;
    a_req_valid = 1; a_op = 4'b0010; a_in1 = 32'd10; a_in2 = 32'd20;
    wait_grant(0, "t6_a");
    @(posedge clk); #1 a_req_valid = 0;
    @(posedge clk); #1 rst = 1;
    @(posedge clk); #1 rst = 0;
    @(negedge clk);
    check("t6_result_cleared", rsp_result, 0);
    check("t6_alu_in1_cleared", alu_in1, 0);
    check("t6_alu_op_cleared", alu_op, 0);
    check("t6_busy_cleared", busy, 0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("t6_no_rsp", a_rsp_valid, 0);
    end
    run_op(0, 4'b0010, 32'd10, 32'd20, 32'd30, 1'b0, "t6_after");

    // Random traffic with random backpressure and occasional resets, checked by the model.
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      af = a_req_valid && a_req_ready;
      bf = b_req_valid && b_req_ready;
      @(posedge clk); #1;
      rst = ($urandom_range(0, 79) == 0);
      if (!a_req_valid || af) begin
        a_req_valid = ($urandom_range(0, 2) != 0);
        rand_ops(a_op, a_in1, a_in2);
      end
      if (!b_req_valid || bf) begin
        b_req_valid = ($urandom_range(0, 2) != 0);
        rand_ops(b_op, b_in1, b_in2);
      end
      a_rsp_ready = $urandom_range(0, 1);
      b_rsp_ready = $urandom_range(0, 1);
    end
    do_reset();
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
